// File: rtl/dac8531_serial_receiver.sv
// DAC8531 3-wire frame receiver: synchronises CS/SCLK/SDO, deserialises 24-bit frames, counts aborted frames.
// Optional SHIFT-state stall timeout enabled by defining DAC8531_RX_TIMEOUT_EN.
module dac8531_serial_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [15:0] RESET_DATA     = 16'd31200,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DA_CS,
  input  logic        DA_SCLK,
  input  logic        DA_SDO,
  output logic [15:0] DATA,
  output logic [1:0]  PD_MODE,
  output logic        DATA_VALID,
  output logic        FRAME_ERR,
  output logic [7:0]  ERR_COUNT,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdo_sync_q;
  logic [SYNC_STAGES:0]   settle_q;
  logic                   cs_dly_q, sclk_dly_q, armed_q;
  logic                   cs_s, sclk_s, sdo_s;
  logic                   cs_fall, cs_rise, sclk_fall;

  state_t       state_q;
  logic [4:0]   bit_cnt_q;
  logic [23:0]  shreg_q;
  logic [15:0]  data_q;
  logic [1:0]   pd_q;
  logic         valid_q, err_q, busy_q;
  logic [7:0]   err_cnt_q;
  logic [5:0]   hdr_unused;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdo_s  = sdo_sync_q[SYNC_STAGES-1];

  // A CS low level inherited from reset must not look like a falling edge:
  // edges are only honoured once the chain has refilled and CS was seen high.
  assign cs_fall   = armed_q & cs_dly_q & ~cs_s;
  assign cs_rise   = ~cs_dly_q & cs_s;
  assign sclk_fall = sclk_dly_q & ~sclk_s;
  assign hdr_unused = shreg_q[23:18];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      sdo_sync_q  <= '0;
      cs_dly_q    <= 1'b1;
      sclk_dly_q  <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], DA_CS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], DA_SCLK};
      sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], DA_SDO};
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      if (settle_q[SYNC_STAGES] && cs_s) armed_q <= 1'b1;
    end
  end

`ifdef DAC8531_RX_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] idle_cnt_q;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= RESET_DATA;
      pd_q      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
`ifdef DAC8531_RX_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b1;
`ifdef DAC8531_RX_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
        end
        SHIFT: begin
          // CS rise takes priority over a coincident SCLK fall, even on bit 24.
          if (cs_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else if (sclk_fall && !cs_s) begin
            shreg_q   <= {shreg_q[22:0], sdo_s};
            bit_cnt_q <= bit_cnt_q + 5'd1;
`ifdef DAC8531_RX_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
            if (bit_cnt_q == 5'd23) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
`ifdef DAC8531_RX_TIMEOUT_EN
          else if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= WAIT_CS;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          data_q  <= shreg_q[15:0];
          pd_q    <= shreg_q[17:16];
          valid_q <= 1'b1;
          state_q <= WAIT_CS;
        end
        WAIT_CS: begin
          if (cs_s) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA       = data_q;
  assign PD_MODE    = pd_q;
  assign DATA_VALID = valid_q;
  assign FRAME_ERR  = err_q;
  assign ERR_COUNT  = err_cnt_q;
  assign BUSY       = busy_q;

endmodule

// File: doc/dac8531_serial_receiver.md
Name: dac8531_serial_receiver

Overview:
- Receive-side counterpart of the DAC8531 3-wire serial link (DA_CS / DA_SCLK / DA_SDO) driven by the frequency-calibration loop's DAC writer.
- Oversamples the link in the local clock domain, deserialises 24-bit DAC8531 frames and presents the decoded 16-bit DAC code and power-down mode with a one-cycle valid strobe.
- Used as a loopback monitor and as a DAC emulator on boards with an FPGA-side DAC; also counts malformed frames for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser; legal range 2..4.
- RESET_DATA, 16'd31200, value of DATA after reset. Matches the calibration loop's power-on DAC code.
- TIMEOUT_CYCLES, 1024, CLK cycles without an SCLK falling edge while CS is low before the frame is aborted. Used only with the optional feature.

Ports:
- CLK  input  1  system clock; 10 MHz nominal, ≥4x SCLK rate.
- RESET  input  1  asynchronous, active-high reset.
- DA_CS  input  1  frame select (SYNC), active low, asynchronous to CLK.
- DA_SCLK  input  1  serial clock, asynchronous; data sampled on its falling edge.
- DA_SDO  input  1  serial data, MSB first.
- DATA  output  16  last accepted DAC code (frame bits 15:0).
- PD_MODE  output  2  last accepted power-down bits (frame bits 17:16).
- DATA_VALID  output  1  one-cycle pulse when DATA/PD_MODE update.
- FRAME_ERR  output  1  one-cycle pulse on aborted frame.
- ERR_COUNT  output  8  count of aborted frames, saturates at 255.
- BUSY  output  1  high while a frame is being shifted (state SHIFT).

Behaviour:
- Reset values: DATA=RESET_DATA, PD_MODE=0, DATA_VALID=0, FRAME_ERR=0, ERR_COUNT=0, BUSY=0.
- Reset state: IDLE. Synchroniser chains reset to 1 for CS and SCLK and to 0 for SDO.
- Sampling: all three inputs pass through SYNC_STAGES flops. Edges are detected by comparing the synced value with a one-cycle-delayed copy.
- Input timing requirement: SCLK high and low phases must each be ≥2 CLK periods. Faster input is out of spec; behaviour is undefined but must not lock up the FSM.
- State IDLE: on synced CS falling edge → SHIFT, clear 5-bit bit counter and 24-bit shift register.
  - CS already low when leaving reset does not start a frame; a falling edge is required.
- State SHIFT: on each synced SCLK falling edge with synced CS low, shift synced SDO into the LSB and increment the bit counter.
  - When the counter reaches 24 → DONE.
  - CS rising edge with counter <24 → abort: FRAME_ERR pulses, ERR_COUNT increments (saturating), DATA unchanged → IDLE.
- State DONE (one cycle): DATA ← shreg[15:0], PD_MODE ← shreg[17:16], DATA_VALID=1 → WAIT_CS. Bits 23:18 are ignored.
- State WAIT_CS: further SCLK edges are ignored; synced CS high → IDLE. No error is flagged for extra clocks.
- Latency: DATA_VALID asserts SYNC_STAGES+2 CLK cycles after the 24th SCLK falling edge at the pins (4 cycles at default).
- Simultaneous synced CS rise and SCLK fall in the same cycle: CS wins, the SCLK edge is discarded. If that edge would have been bit 24, the frame is aborted.
- CS falling edge while in WAIT_CS is impossible (CS must go high first). CS glitch high then low within SHIFT aborts the first frame and a fresh frame starts only after the return to IDLE.
- Asynchronous RESET mid-frame discards the partial frame without FRAME_ERR. Outputs return to reset values immediately.
- BUSY=1 in SHIFT only.

Optional Feature:
- Macro DAC8531_RX_TIMEOUT_EN.
- Defined: an idle counter runs in SHIFT, cleared on every accepted SCLK falling edge. On reaching TIMEOUT_CYCLES the frame is aborted exactly as a short frame (FRAME_ERR pulse, ERR_COUNT++) and the FSM moves to WAIT_CS.
- Not defined: no counter is instantiated; SHIFT waits indefinitely for SCLK or CS.

Test Plan:
- Frame 0x00_7A10 (PD=00, code 0x7A10), SCLK = CLK/8 → DATA=0x7A10, PD_MODE=0, one DATA_VALID pulse 4 cycles after the 24th falling edge; FRAME_ERR never set.
- Frame 0x03_FFFF → DATA=0xFFFF, PD_MODE=2'b11. Then frame 0x00_0000 → DATA=0x0000, PD_MODE=0, two valid pulses total.
- CS raised after 20 SCLK falls → FRAME_ERR pulse, ERR_COUNT=1, DATA holds the previous value; the next full frame 0x00_1234 is accepted normally.
- 300 consecutive 10-bit aborted frames → ERR_COUNT saturates at 255, no wrap.
- RESET asserted after 12 bits, released with CS still low, then SCLK continues → no DATA_VALID, DATA=31200 until CS high → low and a full new frame.
- With DAC8531_RX_TIMEOUT_EN, TIMEOUT_CYCLES=64: CS low, 5 bits, SCLK stalls 70 cycles → FRAME_ERR at idle count 64, BUSY drops. Without the macro → BUSY stays 1 and no error.
